// File: rtl/timer_pkg.sv
// Shared timer definitions for the alarm datapath: state encoding and day length.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package timer_pkg;

  // Elapsed-time state machine encoding. The values are fixed because other
  // blocks decode the state directly.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  // One day in seconds. The HH:MM:SS display decoder also uses this value.
  localparam int unsigned SECONDS_PER_DAY = 86400;

endpackage

// File: rtl/elapsed_time_counter_if.sv
// Command/status bundle between the alarm controller and the elapsed-time counter.
// Latency: n/a (wires only).
// Backpressure: none. Commands are levels sampled every cycle, and status is always valid.
//
// Ports:
//   start, stop, clear   : command levels (controller -> counter)
//   limit_seconds        : deadline in seconds, 0 = disabled
//   total_seconds_elapsed: registered seconds count
//   tick_1hz             : one-cycle pulse when the count changes
//   limit_reached        : one-cycle pulse when the count lands on the deadline
//   running              : counter is in RUNNING
interface elapsed_time_counter_if;

  logic        start;
  logic        stop;
  logic        clear;
  logic [31:0] limit_seconds;
  logic [31:0] total_seconds_elapsed;
  logic        tick_1hz;
  logic        limit_reached;
  logic        running;

  modport master (
    output start, stop, clear, limit_seconds,
    input  total_seconds_elapsed, tick_1hz, limit_reached, running
  );

  modport slave (
    input  start, stop, clear, limit_seconds,
    output total_seconds_elapsed, tick_1hz, limit_reached, running
  );

endinterface

// File: rtl/tick_gen.sv
// Prescaler: divides the clock by CLK_FREQ_HZ and flags the edge where a second completes.
// Latency: tick is combinational from the prescaler state and is valid on the wrapping edge.
// Backpressure: none. While enable is low the prescaler simply holds its value.
//
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   enable      : advance the prescaler this cycle
//   restart     : zero the prescaler (fresh start from IDLE)
//   hold_clear  : zero the prescaler and suppress any tick (clear command)
//   tick        : the prescaler wraps on this edge
module tick_gen #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  input  logic restart,
  input  logic hold_clear,
  output logic tick
);

  localparam int unsigned   PW   = $clog2(CLK_FREQ_HZ);
  localparam logic [PW-1:0] LAST = PW'(CLK_FREQ_HZ - 1);

  logic [PW-1:0] presc;
  logic          at_last;

  assign at_last = (presc == LAST);

  // When enable is gated off at LAST, the prescaler holds at LAST. The
  // suppressed tick then fires on the first enabled edge after resuming.
  assign tick = enable && !hold_clear && !restart && at_last;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc <= '0;
    end else if (hold_clear || restart) begin
      presc <= '0;
    end else if (enable) begin
      presc <= at_last ? '0 : presc + PW'(1);
    end
  end

endmodule

// File: rtl/elapsed_time_counter.sv
// Elapsed-seconds counter: 1 Hz tick, wrapping seconds count, and deadline pulse for entry-delay expiry.
// Latency: a command sampled at edge k takes effect at edge k. All outputs are registered and update after that edge.
// Backpressure: none. Commands are levels with priority clear > stop > start.
//
// Ports:
//   CLOCK_50 : sole clock, rising edge
//   resetn   : synchronous active-low reset
//   bus      : elapsed_time_counter_if.slave (commands, deadline, count/tick/limit/running status)
module elapsed_time_counter
  import timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned MAX_SECONDS = 86399
) (
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  elapsed_time_counter_if.slave  bus
);

  localparam logic [31:0] MAX_COUNT = 32'(MAX_SECONDS);

  state_t      state;
  state_t      state_nxt;
  logic        presc_en;
  logic        presc_restart;
  logic        presc_hold_clear;
  logic        presc_tick;
  logic [31:0] count;
  logic [31:0] count_inc;
  logic        tick_q;
  logic        limit_q;

  tick_gen #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_tick_gen (
    .clk        (CLOCK_50),
    .resetn     (resetn),
    .enable     (presc_en),
    .restart    (presc_restart),
    .hold_clear (presc_hold_clear),
    .tick       (presc_tick)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The prescaler runs only on RUNNING edges that are not also being stopped.
  // A stop that lands on the wrap edge therefore holds the prescaler at its
  // last value rather than losing the tick.
  always_comb begin
    state_nxt        = state;
    presc_en         = 1'b0;
    presc_restart    = 1'b0;
    presc_hold_clear = 1'b0;
    if (bus.clear) begin
      state_nxt        = IDLE;
      presc_hold_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state_nxt     = RUNNING;
            presc_restart = 1'b1;
          end
        end
        RUNNING: begin
          if (bus.stop) begin
            state_nxt = PAUSED;
          end else begin
            presc_en = 1'b1;
          end
        end
        PAUSED: begin
          // The prescaler is left as is, so the partial second carries over.
          if (bus.start && !bus.stop) begin
            state_nxt = RUNNING;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign count_inc = (count == MAX_COUNT) ? 32'd0 : count + 32'd1;

  // tick_1hz and limit_reached are registered together with the count, so
  // they line up with the new value.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      count   <= '0;
      tick_q  <= 1'b0;
      limit_q <= 1'b0;
    end else begin
      tick_q  <= 1'b0;
      limit_q <= 1'b0;
      if (presc_hold_clear) begin
        count <= '0;
      end else if (presc_tick) begin
        count   <= count_inc;
        tick_q  <= 1'b1;
        limit_q <= (bus.limit_seconds != 32'd0) && (count_inc == bus.limit_seconds);
      end
    end
  end

  assign bus.total_seconds_elapsed = count;
  assign bus.tick_1hz              = tick_q;
  assign bus.limit_reached         = limit_q;
  assign bus.running               = (state == RUNNING);

endmodule

// File: doc/elapsed_time_counter.md
# elapsed_time_counter

Free-running elapsed-seconds source for the entry/burglar alarm datapath. It divides the board clock down to a 1 Hz tick and accumulates a 32-bit `total_seconds_elapsed` count that the HH:MM:SS seven-segment display decodes. It also raises a one-cycle `limit_reached` pulse when the count hits a programmable deadline, which the alarm controller uses for entry-delay expiry.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 50_000_000: clock cycles per second. Must be ≥ 2. Benches use 4.
- `MAX_SECONDS`, default 86399: last count value (23:59:59). The next tick wraps the count to 0.

Ports (clock and reset first):
- `CLOCK_50`, in, 1: sole clock. All logic is on the rising edge.
- `resetn`, in, 1: reset, synchronous and active-low.
- `start`, in, 1: level sampled each cycle. Begins or resumes counting.
- `stop`, in, 1: pauses counting and holds the count.
- `clear`, in, 1: zeroes the count and prescaler, then returns to IDLE.
- `limit_seconds`, in, 32: deadline in seconds. 0 disables the deadline.
- `total_seconds_elapsed`, out, 32: current count, registered.
- `tick_1hz`, out, 1: one-cycle pulse, high in the cycle the new count is visible.
- `limit_reached`, out, 1: one-cycle pulse, high in the cycle the count becomes equal to `limit_seconds`.
- `running`, out, 1: high while in RUNNING.

## Operation
- The state machine has three states: IDLE, RUNNING, PAUSED.
- Command priority is `clear` > `stop` > `start` when several are high in the same cycle.
- `clear`, from any state: next state is IDLE, count ← 0, prescaler ← 0. No tick and no `limit_reached` in that cycle.
- `stop`: RUNNING → PAUSED. Ignored in IDLE and PAUSED.
- `start` from IDLE → RUNNING, with prescaler ← 0.
- `start` from PAUSED → RUNNING, with the prescaler held. A partial second is kept, not lost.
- `start` in RUNNING is ignored. The prescaler is not restarted.
- Prescaler is an unsigned counter, 0..CLK_FREQ_HZ-1, width `$clog2(CLK_FREQ_HZ)`. It advances only in RUNNING.
  - At CLK_FREQ_HZ-1 it returns to 0, increments the count, and asserts `tick_1hz` for one cycle.
- Count arithmetic is unsigned 32-bit.
  - If count == MAX_SECONDS at a tick, the next value is 0. The count never exceeds MAX_SECONDS.
- `limit_reached` asserts on a tick whose new count equals `limit_seconds`, when `limit_seconds` ≠ 0.
  - `limit_seconds` is compared at each tick. Changing it between ticks is legal.
  - A limit already passed does not fire until wrap-around brings the count back to it.
  - A limit above MAX_SECONDS never fires.
- `running` reflects the current state register.

## Timing
- Reset values (cycle after `resetn` is sampled low): state IDLE, prescaler 0, `total_seconds_elapsed` 0, `tick_1hz` 0, `limit_reached` 0, `running` 0.
- Reset overrides all commands.
- A command sampled at edge k takes effect at edge k: state and `running` change in the following cycle.
- With `start` sampled from IDLE at edge k, the first tick occurs at edge k+CLK_FREQ_HZ.
  - `tick_1hz` = 1 and the count = 1 are visible in the cycle after that edge.
  - Subsequent ticks follow every CLK_FREQ_HZ cycles.
- `stop` sampled on the same edge the prescaler would wrap: the tick is suppressed, and the prescaler holds at CLK_FREQ_HZ-1.
  - On resume, the tick fires on the first RUNNING edge.
- `tick_1hz` and `limit_reached` are registered and coincide with the updated count. No combinational path from inputs to outputs.

## Structure
- Shared package `timer_pkg` holds:
  - state encoding constants: IDLE = 2'd0, RUNNING = 2'd1, PAUSED = 2'd2;
  - `SECONDS_PER_DAY` = 86400.
- The display decoder also uses `SECONDS_PER_DAY` from this package.
- Sub-module `tick_gen`: the prescaler with `enable`, `restart`, `hold_clear` inputs and a `tick` output.
- The count register, state machine and limit compare stay in the top module.

## Test plan
All scenarios use CLK_FREQ_HZ = 4.
- **Reset, then start:** `resetn` low 2 cycles, then `start` for 1 cycle.
  - Required: count = 0 and `running` = 0 during reset.
  - Required: count reaches 1 with `tick_1hz` exactly 4 cycles after the start edge, then 2 after 4 more cycles.
- **Pause preserves the partial second:** start, run 6 cycles, `stop`, hold 10 cycles, `start`.
  - Required: count stays 1 while paused.
  - Required: count reaches 2 exactly 2 running cycles after resume.
- **Simultaneous commands:** `clear` + `stop` + `start` together while RUNNING at count 5.
  - Required: count = 0, state IDLE, `running` = 0.
  - Then `stop` + `start` together in RUNNING: PAUSED.
- **Wrap-around:** MAX_SECONDS = 3, run 16 cycles.
  - Required: count sequence 1, 2, 3, 0, with `tick_1hz` on each change.
- **Deadline:**
  - `limit_seconds` = 3: single `limit_reached` pulse coincident with count = 3, none at other counts.
  - `limit_seconds` = 0: no pulse over 40 cycles.
  - Raise the limit to 5 at count = 4: pulse at 5.
- **Reset mid-operation:** `resetn` low for 1 cycle at count 2 with prescaler at 2.
  - Required: all outputs return to reset values next cycle.
  - Required: no tick until a new `start` is issued.
